// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - data-memory arbiter between core and host with host lock bursts

`ifndef MEM_W
`define MEM_W 32
`endif
`ifndef DMEMCSW
`define DMEMCSW 2
`endif
`ifndef SUBDMEMADDRW
`define SUBDMEMADDRW 10
`endif

module dmem_arb #(
    parameter int MEM_W     = `MEM_W,
    parameter int DMEMCSW   = `DMEMCSW,
    parameter int ADDRW     = `SUBDMEMADDRW,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               reset_b,

    input  logic               c_req,
    input  logic               c_rw,
    input  logic [DMEMCSW-1:0] c_cs,
    input  logic [ADDRW-1:0]   c_addr,
    input  logic [MEM_W-1:0]   c_wdat,
    output logic               c_gnt,
    output logic               c_rvalid,

    input  logic               h_req,
    input  logic               h_rw,
    input  logic [DMEMCSW-1:0] h_cs,
    input  logic [ADDRW-1:0]   h_addr,
    input  logic [MEM_W-1:0]   h_wdat,
    input  logic               h_lock,
    output logic               h_gnt,
    output logic               h_rvalid,

    output logic [MEM_W-1:0]   rdat,

    output logic               mem_rw,
    output logic [DMEMCSW-1:0] mem_cs,
    output logic [ADDRW-1:0]   mem_addr,
    output logic [MEM_W-1:0]   mem_wdat,
    input  logic [MEM_W-1:0]   mem_rdat
);

    localparam int CNTW = $clog2(MAX_BURST + 1);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_BURST);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        HLOCK = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_h;
    logic            last_h_nxt;
    logic [CNTW-1:0] burst_cnt;
    logic [CNTW-1:0] burst_cnt_nxt;
    logic            gnt_c;
    logic            gnt_h;

    // State, round-robin pointer and burst counter; last_h=1 means host won last
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= ARB;
            last_h    <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last_h    <= last_h_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grant decision and next-state logic
    always_comb begin
        state_nxt     = state;
        last_h_nxt    = last_h;
        burst_cnt_nxt = burst_cnt;
        gnt_c         = 1'b0;
        gnt_h         = 1'b0;
        case (state)
            ARB: begin
                if (c_req && h_req) begin
                    if (last_h) gnt_c = 1'b1;
                    else        gnt_h = 1'b1;
                end else if (c_req) begin
                    gnt_c = 1'b1;
                end else if (h_req) begin
                    gnt_h = 1'b1;
                end
                if (gnt_h && h_lock) begin
                    state_nxt     = HLOCK;
                    burst_cnt_nxt = CNTW'(1);
                end
            end
            HLOCK: begin
                if (burst_cnt >= MAX_CNT) begin
                    // Burst exhausted: a waiting core breaks the lock, otherwise host keeps going
                    if (c_req) begin
                        gnt_c     = 1'b1;
                        state_nxt = ARB;
                    end else if (h_req) begin
                        gnt_h = 1'b1;
                    end
                end else if (h_req) begin
                    gnt_h         = 1'b1;
                    burst_cnt_nxt = burst_cnt + CNTW'(1);
                end else if (c_req) begin
                    gnt_c = 1'b1;
                end
                if (!h_lock) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
        if (gnt_c)      last_h_nxt = 1'b0;
        else if (gnt_h) last_h_nxt = 1'b1;
    end

    // Grants are suppressed while reset is held so nothing reaches the memory
    always_comb begin
        c_gnt = gnt_c & reset_b;
        h_gnt = gnt_h & reset_b;
    end

    // Memory port mux; idle value is a harmless read of bank 0 address 0
    always_comb begin
        mem_rw   = 1'b1;
        mem_cs   = '0;
        mem_addr = '0;
        mem_wdat = '0;
        if (c_gnt) begin
            mem_rw   = c_rw;
            mem_cs   = c_cs;
            mem_addr = c_addr;
            mem_wdat = c_wdat;
        end else if (h_gnt) begin
            mem_rw   = h_rw;
            mem_cs   = h_cs;
            mem_addr = h_addr;
            mem_wdat = h_wdat;
        end
    end

    // Read-data valid follows a granted read by one cycle, matching memory latency
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            c_rvalid <= 1'b0;
            h_rvalid <= 1'b0;
        end else begin
            c_rvalid <= gnt_c & c_rw;
            h_rvalid <= gnt_h & h_rw;
        end
    end

    // Shared read data, zero when no requester is being returned data
    always_comb begin
        rdat = '0;
        if (c_rvalid || h_rvalid) rdat = mem_rdat;
    end

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - directed self-checking bench for dmem_arb

module tb_dmem_arb;

    localparam int MEM_W     = 8;
    localparam int DMEMCSW   = 2;
    localparam int ADDRW     = 4;
    localparam int MAX_BURST = 8;

    logic               clk;
    logic               reset_b;
    logic               c_req, c_rw;
    logic [DMEMCSW-1:0] c_cs;
    logic [ADDRW-1:0]   c_addr;
    logic [MEM_W-1:0]   c_wdat;
    logic               c_gnt, c_rvalid;
    logic               h_req, h_rw, h_lock;
    logic [DMEMCSW-1:0] h_cs;
    logic [ADDRW-1:0]   h_addr;
    logic [MEM_W-1:0]   h_wdat;
    logic               h_gnt, h_rvalid;
    logic [MEM_W-1:0]   rdat;
    logic               mem_rw;
    logic [DMEMCSW-1:0] mem_cs;
    logic [ADDRW-1:0]   mem_addr;
    logic [MEM_W-1:0]   mem_wdat;
    logic [MEM_W-1:0]   mem_rdat;

    logic [MEM_W-1:0]   mem_arr [0:(1<<ADDRW)-1];
    logic [MEM_W-1:0]   mem_q;

    int n_cmp;
    int n_bad;

    dmem_arb #(
        .MEM_W(MEM_W), .DMEMCSW(DMEMCSW), .ADDRW(ADDRW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset_b(reset_b),
        .c_req(c_req), .c_rw(c_rw), .c_cs(c_cs), .c_addr(c_addr), .c_wdat(c_wdat),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .h_req(h_req), .h_rw(h_rw), .h_cs(h_cs), .h_addr(h_addr), .h_wdat(h_wdat),
        .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .rdat(rdat),
        .mem_rw(mem_rw), .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory with one-cycle latency
    always @(posedge clk) begin
        if (mem_cs != '0) begin
            if (!mem_rw) mem_arr[mem_addr] <= mem_wdat;
            mem_q <= mem_arr[mem_addr];
        end
    end
    assign mem_rdat = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        c_req = 0; c_rw = 1; c_cs = 0; c_addr = 0; c_wdat = 0;
        h_req = 0; h_rw = 1; h_cs = 0; h_addr = 0; h_wdat = 0; h_lock = 0;
    endtask

    task automatic do_reset;
        reset_b = 0;
        idle_inputs();
        next_cyc();
        reset_b = 1;
    endtask

    initial begin
        logic [10:0] burst_h;
        n_cmp = 0;
        n_bad = 0;
        mem_q = '0;
        for (int i = 0; i < (1 << ADDRW); i++) mem_arr[i] = MEM_W'(i);
        mem_arr[5] = 8'h3C;
        reset_b = 0;
        idle_inputs();

        // Reset state
        @(negedge clk);
        check("rst_c_gnt", c_gnt, 0);
        check("rst_h_gnt", h_gnt, 0);
        check("rst_mem_cs", mem_cs, 0);
        check("rst_mem_rw", mem_rw, 1);
        check("rst_rdat", rdat, 0);
        check("rst_c_rvalid", c_rvalid, 0);
        check("rst_h_rvalid", h_rvalid, 0);
        next_cyc();
        reset_b = 1;

        // Core-only read
        c_req = 1; c_rw = 1; c_cs = 2'b01; c_addr = 4'd5;
        @(negedge clk);
        check("core_gnt", c_gnt, 1);
        check("core_h_gnt", h_gnt, 0);
        check("core_mem_addr", mem_addr, 5);
        check("core_mem_cs", mem_cs, 1);
        check("core_mem_rw", mem_rw, 1);
        next_cyc();
        c_req = 0;
        @(negedge clk);
        check("core_rvalid", c_rvalid, 1);
        check("core_h_rvalid", h_rvalid, 0);
        check("core_rdat", rdat, 8'h3C);
        check("idle_mem_cs", mem_cs, 0);

        // Unlocked conflict after reset alternates C,H,C,H...
        do_reset();
        c_req = 1; c_rw = 0; c_cs = 1; c_addr = 4'd7;
        h_req = 1; h_rw = 0; h_cs = 1; h_addr = 4'd8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rr_c_gnt%0d", i), c_gnt, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr_h_gnt%0d", i), h_gnt, (i % 2 == 1) ? 1 : 0);
            next_cyc();
        end
        idle_inputs();
        @(negedge clk);
        check("rr_no_wvalid", c_rvalid | h_rvalid, 0);

        // Locked burst: C, then 8 H, then C breaks the lock, then H again
        do_reset();
        burst_h = 11'b10111111110;
        c_req = 1; c_rw = 1; c_cs = 1; c_addr = 0;
        h_req = 1; h_rw = 1; h_cs = 1; h_addr = 0; h_lock = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check($sformatf("burst_h%0d", i), h_gnt, burst_h[i]);
            check($sformatf("burst_c%0d", i), c_gnt, !burst_h[i]);
            next_cyc();
        end

        // Lock without core competition: 12 host grants, counter saturates
        do_reset();
        h_req = 1; h_rw = 1; h_cs = 1; h_lock = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("sat_h%0d", i), h_gnt, 1);
            next_cyc();
        end
        c_req = 1; c_rw = 1; c_cs = 1;
        @(negedge clk);
        check("sat_core_break", c_gnt, 1);
        check("sat_host_held", h_gnt, 0);
        next_cyc();

        // Host write then read back
        do_reset();
        h_req = 1; h_rw = 0; h_cs = 2'b10; h_addr = 4'd3; h_wdat = 8'hA5;
        @(negedge clk);
        check("wr_gnt", h_gnt, 1);
        check("wr_mem_rw", mem_rw, 0);
        check("wr_mem_wdat", mem_wdat, 8'hA5);
        check("wr_mem_cs", mem_cs, 2'b10);
        next_cyc();
        h_rw = 1; h_wdat = 0;
        @(negedge clk);
        check("wr_no_rvalid", h_rvalid, 0);
        check("rd_gnt", h_gnt, 1);
        next_cyc();
        h_req = 0;
        @(negedge clk);
        check("rd_rvalid", h_rvalid, 1);
        check("rd_c_rvalid", c_rvalid, 0);
        check("rd_rdat", rdat, 8'hA5);
        next_cyc();
        @(negedge clk);
        check("rd_rvalid_drop", h_rvalid, 0);
        check("rd_rdat_zero", rdat, 0);

        // Reset in the middle of a core read; core had won last beforehand
        c_req = 1; c_rw = 1; c_cs = 1; c_addr = 4'd5;
        next_cyc();
        @(negedge clk);
        check("mid_pre_rvalid", c_rvalid, 1);
        check("mid_gnt", c_gnt, 1);
        reset_b = 0;
        #1;
        check("mid_rst_rvalid", c_rvalid, 0);
        check("mid_rst_gnt", c_gnt, 0);
        check("mid_rst_cs", mem_cs, 0);
        next_cyc();
        reset_b = 1;
        c_req = 0;
        @(negedge clk);
        check("mid_post_rvalid", c_rvalid, 0);
        c_req = 1; h_req = 1; h_rw = 1; h_cs = 1;
        #1;
        check("mid_conflict_c", c_gnt, 1);
        check("mid_conflict_h", h_gnt, 0);
        next_cyc();
        @(negedge clk);
        check("mid_conflict2_h", h_gnt, 1);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
